spi_master_seq: RTL and testbench

- Sequencing SPI master that frames byte streams into chip-select-bounded transactions toward the team's SPI slave models (mode 0, MSB first, CS active-low).
- Deasserting CS ends the frame; the slave flushes its buffer on that edge.
- Takes bytes over a valid/ready stream with a last flag, generates spi_clk/mosi/cs with programmable timing, and returns captured MISO bytes.
- Sits between a DPI-driven or CPU-side byte source and the SPI pins.

---
 rtl/spi_master_seq.sv | 99 +++++++++
 tb/tb_spi_master_seq.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_seq.sv
// spi_master_seq: mode-0 SPI master framing a valid/ready byte stream into CS-bounded transactions
module spi_master_seq #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    input  logic       tx_last_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       busy_o,
    output logic       spi_clk_o,
    output logic       spi_mosi_o,
    output logic       spi_cs_o,
    input  logic       spi_miso_i
);
    typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, WAIT, HOLD, GAP} state_t;
    state_t state, state_nx;
    logic [15:0] cnt, load;
    logic [2:0] bit_cnt;
    logic [7:0] tx_sr, rx_sr;
    logic last, fire, done;
    assign tx_ready_o = !rst_i && (state == IDLE || state == WAIT);
    assign busy_o = !rst_i && state != IDLE;
    assign fire = tx_valid_i && tx_ready_o;
    assign done = cnt == 16'd1;
    assign load = (state_nx == SETUP) ? 16'(CS_SETUP) :
                  (state_nx == LOW || state_nx == HIGH) ? 16'(CLK_DIV) :
                  (state_nx == HOLD) ? 16'(CS_HOLD) :
                  (state_nx == GAP) ? 16'(CS_IDLE) : 16'd0;
    // next-state decode; every timed state leaves when its counter reaches one
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (fire) state_nx = SETUP;
            SETUP:   if (done) state_nx = LOW;
            LOW:     if (done) state_nx = HIGH;
            HIGH:    if (done) state_nx = (bit_cnt != 3'd7) ? LOW : (last ? HOLD : WAIT);
            WAIT:    if (fire) state_nx = LOW;
            HOLD:    if (done) state_nx = GAP;
            GAP:     if (done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // state register plus the shared down-counter, reloaded on every state change
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state_nx != state) ? load : (cnt != 16'd0) ? cnt - 16'd1 : cnt;
        end
    end
    // pin and shift-register updates at byte accept and at each clock-phase boundary
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            spi_cs_o   <= 1'b1;
            spi_clk_o  <= 1'b0;
            spi_mosi_o <= 1'b0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            bit_cnt    <= '0;
            last       <= 1'b0;
        end else begin
            rx_valid_o <= 1'b0;
            if (fire) begin
                tx_sr      <= {tx_data_i[6:0], 1'b0};
                spi_mosi_o <= tx_data_i[7];
                last       <= tx_last_i;
                bit_cnt    <= '0;
                spi_cs_o   <= 1'b0;
            end
            if (state == LOW && done) begin
                spi_clk_o <= 1'b1;
                rx_sr     <= {rx_sr[6:0], spi_miso_i};
            end
            if (state == HIGH && done) begin
                spi_clk_o <= 1'b0;
                bit_cnt   <= bit_cnt + 3'd1;
                if (bit_cnt != 3'd7) begin
                    spi_mosi_o <= tx_sr[7];
                    tx_sr      <= {tx_sr[6:0], 1'b0};
                end else begin
                    rx_data_o  <= rx_sr;
                    rx_valid_o <= 1'b1;
                end
            end
            if (state == HOLD && done) spi_cs_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_spi_master_seq.sv
// tb_spi_master_seq: scoreboard bench for spi_master_seq with a mode-0 slave model
module tb_spi_master_seq;
    logic clk_i = 1'b0, rst_i = 1'b1;
    logic [7:0] tx_data = 8'h00, rx_data;
    logic tx_valid = 1'b0, tx_last = 1'b0, tx_ready, rx_valid, busy, sclk, mosi, cs, miso = 1'b0;
    logic [7:0] tx_data1 = 8'h00, rx_data1;
    logic tx_valid1 = 1'b0, tx_last1 = 1'b0, tx_ready1, rx_valid1, busy1, sclk1, mosi1, cs1;
    logic miso1 = 1'b1;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] miso;
        int cs_low;
        int busy;
        int rises;
    } vec_t;
    vec_t vecs[4];

    int checks = 0, errors = 0, cyc = 0, slot = 0;
    logic [7:0] miso_arr[64];
    logic [7:0] exp_tx[$], exp_rx[$], exp_rx1[$];
    int rise_t[$], rise1_t[$];
    int rises = 0, nb = 0, rx_pulses = 0, cs_rises = 0;
    int cs_low_cnt = 0, last_cs_low = 0, cs_high_cnt = 0, last_cs_high = 0;
    int busy_cnt = 0, last_busy = 0, idle_run = 0, max_idle_run = 0;
    int rises1 = 0, rx1_pulses = 0, cs1_low_cnt = 0, last_cs1_low = 0;
    logic [7:0] acc = 8'h00;
    logic p_sclk, p_cs, p_busy, p_mosi, p_sclk1, p_cs1;
    logic p2_cs, p2_k;
    int mbit = 0, bidx = 0;

    spi_master_seq #(.CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
        .tx_last_i(tx_last), .tx_ready_o(tx_ready), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
        .busy_o(busy), .spi_clk_o(sclk), .spi_mosi_o(mosi), .spi_cs_o(cs), .spi_miso_i(miso));

    spi_master_seq #(.CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(4)) dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .tx_data_i(tx_data1), .tx_valid_i(tx_valid1),
        .tx_last_i(tx_last1), .tx_ready_o(tx_ready1), .rx_data_o(rx_data1), .rx_valid_o(rx_valid1),
        .busy_o(busy1), .spi_clk_o(sclk1), .spi_mosi_o(mosi1), .spi_cs_o(cs1), .spi_miso_i(miso1));

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // slave model: presents bit7 at CS fall, shifts on each falling spi_clk, drops partial bytes
    always @(cs or sclk) begin
        if (p2_cs === 1'b1 && cs === 1'b0) begin
            mbit = 0;
            miso = miso_arr[bidx[5:0]][3'(7 - mbit)];
        end else if (p2_cs === 1'b0 && cs === 1'b1) begin
            if (mbit != 0) bidx++;
            mbit = 0;
        end else if (p2_k === 1'b1 && sclk === 1'b0 && cs === 1'b0) begin
            mbit++;
            if (mbit == 8) begin
                mbit = 0;
                bidx++;
            end
            miso = miso_arr[bidx[5:0]][3'(7 - mbit)];
        end
        p2_cs = cs;
        p2_k = sclk;
    end

    // monitor and scoreboard for the CLK_DIV=2 instance
    always @(negedge clk_i) begin
        if (rst_i) nb = 0;
        if (sclk === 1'b1 && p_sclk === 1'b0) begin
            rises++;
            rise_t.push_back(cyc);
            acc = {acc[6:0], mosi};
            nb++;
            if (nb == 8) begin
                nb = 0;
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mosi_byte: got %0h with nothing expected", acc);
                end else check("mosi_byte", 32'(acc), 32'(exp_tx.pop_front()));
            end
        end
        if (sclk === 1'b1) check("mosi_hold", 32'(mosi), 32'(p_mosi));
        if (cs === 1'b0) cs_low_cnt++;
        else if (p_cs === 1'b0) begin
            last_cs_low = cs_low_cnt;
            cs_low_cnt = 0;
            cs_rises++;
        end
        if (cs === 1'b1) cs_high_cnt++;
        else if (p_cs === 1'b1) begin
            last_cs_high = cs_high_cnt;
            cs_high_cnt = 0;
        end
        if (busy === 1'b1) busy_cnt++;
        else if (p_busy === 1'b1) begin
            last_busy = busy_cnt;
            busy_cnt = 0;
        end
        if (cs === 1'b0 && sclk === 1'b0) begin
            idle_run++;
            if (idle_run > max_idle_run) max_idle_run = idle_run;
        end else idle_run = 0;
        if (rx_valid === 1'b1) begin
            rx_pulses++;
            if (exp_rx.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_data: got %0h with nothing expected", rx_data);
            end else check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
        end
        p_sclk = sclk;
        p_cs = cs;
        p_busy = busy;
        p_mosi = mosi;
    end

    // monitor for the CLK_DIV=1 instance
    always @(negedge clk_i) begin
        if (sclk1 === 1'b1 && p_sclk1 === 1'b0) begin
            rises1++;
            rise1_t.push_back(cyc);
            check("div1_mosi", 32'(mosi1), 1);
        end
        if (cs1 === 1'b0) cs1_low_cnt++;
        else if (p_cs1 === 1'b0) begin
            last_cs1_low = cs1_low_cnt;
            cs1_low_cnt = 0;
        end
        if (rx_valid1 === 1'b1) begin
            rx1_pulses++;
            if (exp_rx1.size() != 0) check("div1_rx", 32'(rx_data1), 32'(exp_rx1.pop_front()));
        end
        p_sclk1 = sclk1;
        p_cs1 = cs1;
    end

    task automatic queue_byte(input logic [7:0] t, input logic [7:0] m);
        miso_arr[slot[5:0]] = m;
        slot++;
        exp_tx.push_back(t);
        exp_rx.push_back(m);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, input logic hold);
        logic got;
        got = 1'b0;
        tx_data = d;
        tx_last = l;
        tx_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (tx_ready) begin
                got = 1'b1;
                break;
            end
        end
        check("accept", 32'(got), 1);
        @(posedge clk_i);
        #1;
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_i);
            if (!busy) break;
        end
        check("idle", 32'(busy), 0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_rx();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (rx_valid) break;
        end
        check("rx_seen", 32'(rx_valid), 1);
    endtask

    initial begin
        int r0, p0, c0;
        vecs[0] = '{8'hA5, 8'h3C, 36, 40, 8};
        vecs[1] = '{8'h00, 8'hFF, 36, 40, 8};
        vecs[2] = '{8'hFF, 8'h00, 36, 40, 8};
        vecs[3] = '{8'h81, 8'h7E, 36, 40, 8};
        tx_valid = 1'b1;
        tx_data = 8'h99;
        tx_last = 1'b1;
        @(negedge clk_i);
        check("rst_ready_pre", 32'(tx_ready), 0);
        @(posedge clk_i);
        @(negedge clk_i);
        check("rst_cs", 32'(cs), 1);
        check("rst_sclk", 32'(sclk), 0);
        check("rst_mosi", 32'(mosi), 0);
        check("rst_rx_data", 32'(rx_data), 0);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(tx_ready), 0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        tx_valid = 1'b0;
        @(negedge clk_i);
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_cs", 32'(cs), 1);
        check("post_rst_ready", 32'(tx_ready), 1);
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 4; i++) begin
            queue_byte(vecs[i].tx, vecs[i].miso);
            r0 = rises;
            p0 = rx_pulses;
            send_byte(vecs[i].tx, 1'b1, 1'b0);
            wait_idle();
            check("vec_cs_low", last_cs_low, vecs[i].cs_low);
            check("vec_busy", last_busy, vecs[i].busy);
            check("vec_rises", rises - r0, vecs[i].rises);
            check("vec_rx_pulses", rx_pulses - p0, 1);
        end
        queue_byte(8'h48, 8'h11);
        queue_byte(8'h69, 8'h22);
        queue_byte(8'h0A, 8'h33);
        rise_t.delete();
        r0 = rises;
        p0 = rx_pulses;
        c0 = cs_rises;
        send_byte(8'h48, 1'b0, 1'b1);
        send_byte(8'h69, 1'b0, 1'b1);
        send_byte(8'h0A, 1'b1, 1'b0);
        wait_idle();
        check("stream_rises", rises - r0, 24);
        check("stream_rx_pulses", rx_pulses - p0, 3);
        check("stream_cs_rises", cs_rises - c0, 1);
        check("stream_cs_low", last_cs_low, 102);
        if (rise_t.size() >= 17) begin
            check("stream_space1", rise_t[8] - rise_t[0], 33);
            check("stream_space2", rise_t[16] - rise_t[8], 33);
        end else check("stream_rise_log", rise_t.size(), 24);
        queue_byte(8'hC6, 8'h5A);
        queue_byte(8'h3E, 8'hE1);
        p0 = rx_pulses;
        c0 = cs_rises;
        send_byte(8'hC6, 1'b0, 1'b0);
        wait_rx();
        @(posedge clk_i);
        #1;
        max_idle_run = 0;
        repeat (20) @(posedge clk_i);
        #1;
        check("underrun_cs", 32'(cs), 0);
        send_byte(8'h3E, 1'b1, 1'b0);
        wait_idle();
        check("underrun_idle", 32'(max_idle_run >= 20), 1);
        check("underrun_rx_pulses", rx_pulses - p0, 2);
        check("underrun_cs_rises", cs_rises - c0, 1);
        queue_byte(8'hC3, 8'h81);
        r0 = rises;
        p0 = rx_pulses;
        send_byte(8'hC3, 1'b1, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if (rises >= r0 + 3) break;
            @(posedge clk_i);
            #1;
        end
        check("abort_rises", rises - r0, 3);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("abort_ready", 32'(tx_ready), 0);
        @(posedge clk_i);
        @(negedge clk_i);
        check("abort_cs", 32'(cs), 1);
        check("abort_sclk", 32'(sclk), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_rx_valid", 32'(rx_valid), 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        exp_tx.delete();
        exp_rx.delete();
        repeat (10) @(posedge clk_i);
        #1;
        check("abort_no_rx", rx_pulses - p0, 0);
        queue_byte(8'h55, 8'hAA);
        p0 = rx_pulses;
        send_byte(8'h55, 1'b1, 1'b0);
        wait_idle();
        check("after_abort_rx", rx_pulses - p0, 1);
        queue_byte(8'h96, 8'h69);
        queue_byte(8'h0F, 8'hF0);
        send_byte(8'h96, 1'b1, 1'b0);
        wait_rx();
        tx_data = 8'h0F;
        tx_last = 1'b1;
        tx_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (!busy) break;
            check("ready_hold_gap", 32'(tx_ready), 0);
        end
        check("ready_first_idle", 32'(tx_ready), 1);
        @(posedge clk_i);
        #1;
        tx_valid = 1'b0;
        check("accept_first_idle", 32'(busy), 1);
        wait_idle();
        check("cs_gap", last_cs_high, 5);
        exp_rx1.push_back(8'hFF);
        tx_data1 = 8'hFF;
        tx_last1 = 1'b1;
        tx_valid1 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (tx_ready1) break;
        end
        check("div1_accept", 32'(tx_ready1), 1);
        @(posedge clk_i);
        #1;
        tx_valid1 = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk_i);
            if (!busy1) break;
        end
        @(posedge clk_i);
        #1;
        check("div1_idle", 32'(busy1), 0);
        check("div1_rises", rises1, 8);
        check("div1_rx_pulses", rx1_pulses, 1);
        check("div1_cs_low", last_cs1_low, 20);
        if (rise1_t.size() == 8) check("div1_span", rise1_t[7] - rise1_t[0], 14);
        else check("div1_rise_log", rise1_t.size(), 8);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
